// File: rtl/noise_lfsr_multi.sv
// Multi-variant PSG noise generator: a prescaled or tone-driven trigger
// shifts an LFSR whose width and taps are selected at run time.
module noise_lfsr_multi #(
  parameter int LFSR_MAX_BITS   = 16,
  parameter int RATE_LOG2_0     = 4,
  parameter int RATE_LOG2_1     = 5,
  parameter int RATE_LOG2_2     = 6,
  parameter int CUSTOM_BITS     = 17,
  parameter int CUSTOM_TAP0     = 0,
  parameter int CUSTOM_TAP1     = 3,
  parameter int DEFAULT_VARIANT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     control_write,
  input  logic [2:0]               control,
  input  logic [1:0]               variant,
  input  logic                     driven_by_tone,
  output logic                     out,
  output logic                     shift_strobe,
  output logic [LFSR_MAX_BITS-1:0] lfsr_state
);

  localparam int N  = LFSR_MAX_BITS;
  localparam int CW = RATE_LOG2_2 + 1;

  typedef logic [N-1:0] vec_t;

  // Widths wider than the physical register are clamped so an illegal
  // custom build still elaborates and stays inside the register.
  function automatic int clamp_w(input int w);
    if (w > N) return N;
    if (w < 2) return 2;
    return w;
  endfunction

  function automatic int clamp_t(input int t, input int w);
    if (t < 0)  return 0;
    if (t >= w) return w - 1;
    return t;
  endfunction

  function automatic vec_t bit_at(input int b);
    return vec_t'(1) << b;
  endfunction

  localparam int W0 = clamp_w(15);
  localparam int W1 = clamp_w(16);
  localparam int W2 = clamp_w(15);
  localparam int W3 = clamp_w(CUSTOM_BITS);

  localparam vec_t TOP0 = bit_at(W0 - 1);
  localparam vec_t TOP1 = bit_at(W1 - 1);
  localparam vec_t TOP2 = bit_at(W2 - 1);
  localparam vec_t TOP3 = bit_at(W3 - 1);

  localparam vec_t TAPA0 = bit_at(clamp_t(0, W0));
  localparam vec_t TAPA1 = bit_at(clamp_t(0, W1));
  localparam vec_t TAPA2 = bit_at(clamp_t(0, W2));
  localparam vec_t TAPA3 = bit_at(clamp_t(CUSTOM_TAP0, W3));

  localparam vec_t TAPB0 = bit_at(clamp_t(1, W0));
  localparam vec_t TAPB1 = bit_at(clamp_t(3, W1));
  localparam vec_t TAPB2 = bit_at(clamp_t(4, W2));
  localparam vec_t TAPB3 = bit_at(clamp_t(CUSTOM_TAP1, W3));

  // The top bit of the active width doubles as the seed value.
  function automatic vec_t top_of(input logic [1:0] v);
    case (v)
      2'd0:    return TOP0;
      2'd1:    return TOP1;
      2'd2:    return TOP2;
      default: return TOP3;
    endcase
  endfunction

  function automatic vec_t tap_a_of(input logic [1:0] v);
    case (v)
      2'd0:    return TAPA0;
      2'd1:    return TAPA1;
      2'd2:    return TAPA2;
      default: return TAPA3;
    endcase
  endfunction

  function automatic vec_t tap_b_of(input logic [1:0] v);
    case (v)
      2'd0:    return TAPB0;
      2'd1:    return TAPB1;
      2'd2:    return TAPB2;
      default: return TAPB3;
    endcase
  endfunction

  localparam logic [1:0] RESET_VAR  = DEFAULT_VARIANT[1:0];
  localparam vec_t       RESET_SEED = top_of(RESET_VAR);

  logic [2:0]    ctrl_q;
  logic [1:0]    var_q;
  logic [CW-1:0] counter;
  logic          edge_prev;
  vec_t          lfsr;
  logic          strobe_q;

  vec_t top;
  vec_t tap_a;
  vec_t tap_b;
  vec_t shifted;
  logic fb_bit;
  logic source;
  logic trig;

  // Next LFSR value for the latched variant, plus trigger edge detection.
  always_comb begin
    top    = top_of(var_q);
    tap_a  = tap_a_of(var_q);
    tap_b  = tap_b_of(var_q);
    fb_bit = |(lfsr & tap_a);
    if (ctrl_q[2]) fb_bit = fb_bit ^ (|(lfsr & tap_b));
    shifted = ((lfsr >> 1) & (top - vec_t'(1))) | (fb_bit ? top : '0);
    case (ctrl_q[1:0])
      2'd0:    source = counter[RATE_LOG2_0];
      2'd1:    source = counter[RATE_LOG2_1];
      2'd2:    source = counter[RATE_LOG2_2];
      default: source = driven_by_tone;
    endcase
    trig = source & ~edge_prev;
  end

  // A write reloads the seed and arms edge_prev so the trigger must be
  // seen low before the next shift; the counter keeps running through it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      var_q     <= RESET_VAR;
      counter   <= '0;
      edge_prev <= 1'b0;
      lfsr      <= RESET_SEED;
      strobe_q  <= 1'b0;
    end else begin
      if (enable) counter <= counter + 1'b1;
      if (control_write) begin
        ctrl_q    <= control;
        var_q     <= variant;
        lfsr      <= top_of(variant);
        edge_prev <= 1'b1;
        strobe_q  <= 1'b0;
      end else begin
        edge_prev <= source;
        strobe_q  <= trig;
        if (trig) lfsr <= (lfsr == '0) ? top : shifted;
      end
    end
  end

  assign out          = lfsr[0];
  assign shift_strobe = strobe_q;
  assign lfsr_state   = lfsr;

endmodule

// File: tb/tb_noise_lfsr_multi.sv
// Self-checking bench for noise_lfsr_multi: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_noise_lfsr_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        control_write;
  logic [2:0]  control;
  logic [1:0]  variant;
  logic        driven_by_tone;
  logic        out;
  logic        shift_strobe;
  logic [15:0] lfsr_state;

  int checks = 0;
  int errors = 0;

  noise_lfsr_multi #(
    .LFSR_MAX_BITS(16), .RATE_LOG2_0(4), .RATE_LOG2_1(5), .RATE_LOG2_2(6),
    .CUSTOM_BITS(13), .CUSTOM_TAP0(0), .CUSTOM_TAP1(3), .DEFAULT_VARIANT(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .control_write(control_write),
    .control(control), .variant(variant), .driven_by_tone(driven_by_tone),
    .out(out), .shift_strobe(shift_strobe), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  // Reference model: integer LFSR with per-variant width/taps tables.
  int m_width [4] = '{15, 16, 15, 13};
  int m_tap0  [4] = '{0, 0, 0, 0};
  int m_tap1  [4] = '{1, 3, 4, 3};
  int m_rate  [3] = '{4, 5, 6};
  int m_ctrl, m_var, m_cnt, m_ep, m_lfsr, m_strobe;
  bit m_valid = 0;

  always @(posedge clk) begin
    int src, nf, w, fb, edge_now;
    if (reset) begin
      m_ctrl = 0; m_var = 0; m_cnt = 0; m_ep = 0;
      m_lfsr = 1 << 14; m_strobe = 0; m_valid = 1;
    end else if (m_valid) begin
      nf  = m_ctrl & 3;
      src = (nf == 3) ? int'(driven_by_tone) : ((m_cnt >> m_rate[nf]) & 1);
      if (control_write) begin
        m_ctrl = int'(control); m_var = int'(variant);
        m_lfsr = 1 << (m_width[m_var] - 1); m_ep = 1; m_strobe = 0;
      end else begin
        edge_now = src & (m_ep ^ 1);
        m_ep = src;
        m_strobe = edge_now;
        if (edge_now == 1) begin
          w = m_width[m_var];
          if (m_lfsr == 0) m_lfsr = 1 << (w - 1);
          else begin
            fb = (m_lfsr >> m_tap0[m_var]) & 1;
            if (m_ctrl[2]) fb = fb ^ ((m_lfsr >> m_tap1[m_var]) & 1);
            m_lfsr = (m_lfsr >> 1) | (fb << (w - 1));
          end
        end
      end
      if (enable) m_cnt = (m_cnt + 1) % 128;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model lfsr_state", 32'(lfsr_state), m_lfsr);
      checkOutput("model shift_strobe", 32'(shift_strobe), m_strobe);
      checkOutput("model out", 32'(out), m_lfsr & 1);
    end
  end

  task automatic applyStimulus(input logic r, input logic en, input logic cw,
                               input logic [2:0] ctl, input logic [1:0] vr, input logic tone);
    reset = r; enable = en; control_write = cw;
    control = ctl; variant = vr; driven_by_tone = tone;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tonePulse(input logic [2:0] ctl, input logic [1:0] vr);
    applyStimulus(0, 0, 0, ctl, vr, 0);
    applyStimulus(0, 0, 0, ctl, vr, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int strobes;
    int shifts;
    logic tone;

    // Reset, then white variant 0 driven by counter bit 4.
    applyStimulus(1, 1, 0, 3'b000, 2'd0, 0);
    checkOutput("reset lfsr", 32'(lfsr_state), 32'h4000);
    checkOutput("reset strobe", 32'(shift_strobe), 0);
    checkOutput("reset out", 32'(out), 0);
    applyStimulus(0, 1, 1, 3'b100, 2'd0, 0);
    for (int cyc = 2; cyc <= 49; cyc++) begin
      applyStimulus(0, 1, 0, 3'b100, 2'd0, 0);
      if (cyc == 16) checkOutput("t1 before first shift", 32'(lfsr_state), 32'h4000);
      if (cyc == 17) begin
        checkOutput("t1 first shift lfsr", 32'(lfsr_state), 32'h2000);
        checkOutput("t1 first shift strobe", 32'(shift_strobe), 1);
      end
      if (cyc > 17 && cyc < 49 && shift_strobe) checkOutput("t1 early strobe", 32'(cyc), 49);
      if (cyc == 49) begin
        checkOutput("t1 second shift lfsr", 32'(lfsr_state), 32'h1000);
        checkOutput("t1 second shift strobe", 32'(shift_strobe), 1);
      end
    end

    // Variant 0 periodic, tone driven for fast shifting.
    applyStimulus(0, 0, 1, 3'b011, 2'd0, 0);
    for (int s = 1; s <= 15; s++) begin
      tonePulse(3'b011, 2'd0);
      if (s == 14) begin
        checkOutput("t2 lfsr after 14", 32'(lfsr_state), 32'h0001);
        checkOutput("t2 out after 14", 32'(out), 1);
      end
      if (s == 15) checkOutput("t2 lfsr after 15", 32'(lfsr_state), 32'h4000);
    end

    // Variant 1 white.
    applyStimulus(0, 0, 1, 3'b111, 2'd1, 0);
    checkOutput("t3 seed", 32'(lfsr_state), 32'h8000);
    for (int s = 1; s <= 13; s++) begin
      tonePulse(3'b111, 2'd1);
      if (s == 12) checkOutput("t3 lfsr after 12", 32'(lfsr_state), 32'h0008);
      if (s == 13) checkOutput("t3 lfsr after 13", 32'(lfsr_state), 32'h8004);
    end

    // Tone edges with enable low: only rising edges shift.
    strobes = 0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 0, 0, 3'b111, 2'd1, 0);
      checkOutput("t4 strobe after fall", 32'(shift_strobe), 0);
      strobes += int'(shift_strobe);
      applyStimulus(0, 0, 0, 3'b111, 2'd1, 1);
      checkOutput("t4 strobe after rise", 32'(shift_strobe), 1);
      strobes += int'(shift_strobe);
    end
    applyStimulus(0, 0, 0, 3'b111, 2'd1, 0);
    strobes += int'(shift_strobe);
    checkOutput("t4 total shifts", 32'(strobes), 3);

    // Write colliding with a trigger edge on variant 2.
    applyStimulus(0, 0, 1, 3'b111, 2'd2, 0);
    for (int s = 0; s < 5; s++) tonePulse(3'b111, 2'd2);
    applyStimulus(0, 0, 0, 3'b111, 2'd2, 0);
    applyStimulus(0, 0, 1, 3'b111, 2'd2, 1);
    checkOutput("t5 write lfsr", 32'(lfsr_state), 32'h4000);
    checkOutput("t5 write strobe", 32'(shift_strobe), 0);
    applyStimulus(0, 0, 0, 3'b111, 2'd2, 1);
    checkOutput("t5 hold lfsr", 32'(lfsr_state), 32'h4000);
    checkOutput("t5 hold strobe", 32'(shift_strobe), 0);
    tonePulse(3'b111, 2'd2);
    checkOutput("t5 next shift", 32'(lfsr_state), 32'h2000);

    // Reset mid-run with variant 1 latched; variant input toggles ignored.
    applyStimulus(0, 1, 1, 3'b101, 2'd1, 0);
    for (int c = 0; c < 40; c++) applyStimulus(0, 1, 0, 3'b101, 2'd1, 0);
    applyStimulus(1, 1, 0, 3'b110, 2'd2, 1);
    checkOutput("t6 reset lfsr", 32'(lfsr_state), 32'h4000);
    checkOutput("t6 reset strobe", 32'(shift_strobe), 0);
    checkOutput("t6 reset out", 32'(out), 0);
    shifts = 0;
    for (int cyc = 1; cyc <= 600 && shifts < 15; cyc++) begin
      applyStimulus(0, 1, 0, 3'($urandom), 2'($urandom), 1'($urandom));
      if (cyc == 16) checkOutput("t6 before first shift", 32'(lfsr_state), 32'h4000);
      if (cyc == 17) checkOutput("t6 first shift", 32'(lfsr_state), 32'h2000);
      if (shift_strobe) shifts++;
    end
    checkOutput("t6 shift count within budget", 32'(shifts), 15);
    checkOutput("t6 lfsr after 15", 32'(lfsr_state), 32'h4000);

    // Random traffic against the model.
    tone = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) tone = ~tone;
      applyStimulus(($urandom_range(0, 199) == 0), 1'($urandom),
                    ($urandom_range(0, 39) == 0), 3'($urandom), 2'($urandom), tone);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
